// File: rtl/phoneme_speech_player.sv
// Phoneme playback responder: table lookup, then paced 8-bit PCM streaming from the sample ROM.
// Optional feature macro PHONEME_TAIL_EN appends TAIL_SAMPLES midscale samples after each phoneme.
module phoneme_speech_player #(
  parameter int SAMPLE_DIV   = 6250,
  parameter int ADDR_W       = 16,
  parameter int NUM_PHONEMES = 64,
  parameter int TAIL_SAMPLES = 16
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start_phoneme_output,
  input  logic [7:0]        phoneme_sel,
  output logic              phoneme_speech_busy,
  output logic [7:0]        tbl_idx,
  input  logic [ADDR_W-1:0] tbl_start,
  input  logic [15:0]       tbl_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        sample_out,
  output logic              sample_valid
);

`ifdef PHONEME_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, REJECT, LOOKUP, LOAD, FETCH, WAIT_TICK, TAIL, FINISH
  } state_t;

  localparam state_t DONE_STATE = (TAIL_EN && TAIL_SAMPLES > 0) ? TAIL : FINISH;

  state_t           state;
  logic             arm;
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      remaining;
  logic [15:0]      tail_cnt;
  logic             tick;
  logic             accept;
  logic             sel_valid;

  assign tick      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign accept    = (state == IDLE) && start_phoneme_output && arm;
  assign sel_valid = ({1'b0, phoneme_sel} < 9'(NUM_PHONEMES));

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state               <= IDLE;
      arm                 <= 1'b1;
      div_cnt             <= '0;
      remaining           <= '0;
      tail_cnt            <= '0;
      phoneme_speech_busy <= 1'b0;
      tbl_idx             <= '0;
      rom_addr            <= '0;
      sample_out          <= 8'h80;
      sample_valid        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      if (accept || tick) div_cnt <= '0;
      else                div_cnt <= div_cnt + 1'b1;

      // A start held high stays disarmed until it is seen low at least once.
      if (!start_phoneme_output) arm <= 1'b1;
      else if (accept)           arm <= 1'b0;

      case (state)
        IDLE: begin
          phoneme_speech_busy <= 1'b0;
          if (accept) begin
            if (sel_valid) begin
              tbl_idx <= phoneme_sel;
              state   <= LOOKUP;
            end else begin
              state <= REJECT;
            end
          end
        end
        REJECT: begin
          phoneme_speech_busy <= 1'b1;
          state               <= FINISH;
        end
        LOOKUP: begin
          phoneme_speech_busy <= 1'b1;
          state               <= LOAD;
        end
        LOAD: begin
          phoneme_speech_busy <= 1'b1;
          rom_addr            <= tbl_start;
          remaining           <= tbl_len;
          tail_cnt            <= 16'(TAIL_SAMPLES);
          state               <= (tbl_len == 16'd0) ? DONE_STATE : FETCH;
        end
        FETCH: begin
          phoneme_speech_busy <= 1'b1;
          state               <= WAIT_TICK;
        end
        WAIT_TICK: begin
          phoneme_speech_busy <= 1'b1;
          // rom_addr is held here, so the ROM output stays valid until the tick.
          if (tick) begin
            sample_out   <= rom_data;
            sample_valid <= 1'b1;
            rom_addr     <= rom_addr + 1'b1;
            remaining    <= remaining - 1'b1;
            state        <= (remaining == 16'd1) ? DONE_STATE : FETCH;
          end
        end
        TAIL: begin
          phoneme_speech_busy <= 1'b1;
          if (tick) begin
            sample_out   <= 8'h80;
            sample_valid <= 1'b1;
            tail_cnt     <= tail_cnt - 1'b1;
            if (tail_cnt == 16'd1) state <= FINISH;
          end
        end
        FINISH: begin
          phoneme_speech_busy <= 1'b0;
          sample_out          <= 8'h80;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phoneme_speech_player.sv
// Randomized self-checking bench for phoneme_speech_player with table/ROM models and a timing reference.
module tb_phoneme_speech_player;
  localparam int DIV = 4;
  localparam int NUM = 64;
`ifdef PHONEME_TAIL_EN
  localparam int T = 2;
`else
  localparam int T = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sel = 8'd0;
  logic        busy;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_start;
  logic [15:0] tbl_len;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample_out;
  logic        sample_valid;

  logic [15:0] start_mem [0:255];
  logic [15:0] len_mem   [0:255];
  logic [7:0]  rom_mem   [0:65535];

  int errors = 0;
  int checks = 0;

  // capture results
  int          rise, fall, nv, nchg;
  int          vt [16];
  logic [7:0]  vd [16];
  logic [15:0] chg [4];
  logic        busy0, bad_idx;
  logic [7:0]  end_out;

  phoneme_speech_player #(
    .SAMPLE_DIV(DIV), .ADDR_W(16), .NUM_PHONEMES(NUM), .TAIL_SAMPLES(2)
  ) dut (
    .clk(clk), .rst_L(rst_L), .start_phoneme_output(start), .phoneme_sel(sel),
    .phoneme_speech_busy(busy), .tbl_idx(tbl_idx), .tbl_start(tbl_start), .tbl_len(tbl_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample_out(sample_out), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tbl_start <= start_mem[tbl_idx];
    tbl_len   <= len_mem[tbl_idx];
    rom_data  <= rom_mem[rom_addr];
  end

  // Issue one request and record the response for `window` cycles after the accepting edge.
  task automatic capture(input logic [7:0] s, input bit hold, input int window);
    logic [15:0] prev;
    rise = -1; fall = -1; nv = 0; nchg = 0; bad_idx = 1'b0;
    for (int i = 0; i < 16; i++) begin vt[i] = -1; vd[i] = 8'h00; end
    for (int i = 0; i < 4; i++) chg[i] = 16'h0000;
    @(negedge clk); sel = s; start = 1'b1;
    @(posedge clk); #1;
    busy0 = busy;
    prev  = rom_addr;
    @(negedge clk);
    if (!hold) start = 1'b0;
    sel = 8'($urandom);
    for (int k = 1; k <= window; k++) begin
      @(posedge clk); #1;
      if (busy && rise < 0) rise = k;
      if (!busy && rise >= 0 && fall < 0) fall = k;
      if (sample_valid && nv < 16) begin vt[nv] = k; vd[nv] = sample_out; nv++; end
      if (rom_addr !== prev && nchg < 4) begin chg[nchg] = rom_addr; nchg++; end
      prev = rom_addr;
      if (tbl_idx == 8'd200) bad_idx = 1'b1;
    end
    end_out = sample_out;
    $display("play sel=%0d rise=%0d fall=%0d pulses=%0d", s, rise, fall, nv);
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (sample_out !== 8'h80) begin errors++; $display("FAIL reset_out got=%h exp=80", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
    checks++; if (tbl_idx !== 8'h00) begin errors++; $display("FAIL reset_tbl_idx got=%h exp=00", tbl_idx); end
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0000", rom_addr); end
    rst_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h30;
    capture(8'd5, 1'b0, 40);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_accept got=%0b exp=0", busy0); end
    checks++; if (rise != 1) begin errors++; $display("FAIL basic_rise got=%0d exp=1", rise); end
    checks++; if (nv != 3 + T) begin errors++; $display("FAIL basic_pulses got=%0d exp=%0d", nv, 3 + T); end
    for (int i = 0; i < 3 + T; i++) begin
      checks++; if (vt[i] != DIV * (i + 1)) begin errors++; $display("FAIL basic_time[%0d] got=%0d exp=%0d", i, vt[i], DIV * (i + 1)); end
      checks++; if (vd[i] !== ((i < 3) ? exp_d[i] : 8'h80)) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, vd[i], (i < 3) ? exp_d[i] : 8'h80); end
    end
    checks++; if (fall != DIV * (3 + T) + 1) begin errors++; $display("FAIL basic_fall got=%0d exp=%0d", fall, DIV * (3 + T) + 1); end
    checks++; if (end_out !== 8'h80) begin errors++; $display("FAIL basic_idle_out got=%h exp=80", end_out); end
  endtask

  task automatic test_invalid();
    capture(8'd200, 1'b0, 20);
    checks++; if (rise != 1) begin errors++; $display("FAIL invalid_rise got=%0d exp=1", rise); end
    checks++; if (fall != 2) begin errors++; $display("FAIL invalid_fall got=%0d exp=2", fall); end
    checks++; if (nv != 0) begin errors++; $display("FAIL invalid_pulses got=%0d exp=0", nv); end
    checks++; if (bad_idx !== 1'b0) begin errors++; $display("FAIL invalid_tbl_idx got=1 exp=0"); end
  endtask

  task automatic test_wrap();
    capture(8'd7, 1'b0, 40);
    checks++; if (chg[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=ffff", chg[0]); end
    checks++; if (chg[1] !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 got=%h exp=0000", chg[1]); end
    checks++; if (nv != 2 + T) begin errors++; $display("FAIL wrap_pulses got=%0d exp=%0d", nv, 2 + T); end
    checks++; if (vd[0] !== rom_mem[65535]) begin errors++; $display("FAIL wrap_data0 got=%h exp=%h", vd[0], rom_mem[65535]); end
    checks++; if (vd[1] !== rom_mem[0]) begin errors++; $display("FAIL wrap_data1 got=%h exp=%h", vd[1], rom_mem[0]); end
  endtask

  task automatic test_rearm();
    int extra;
    capture(8'd9, 1'b1, 40);
    checks++; if (nv != 1 + T) begin errors++; $display("FAIL rearm_first_pulses got=%0d exp=%0d", nv, 1 + T); end
    checks++; if (fall != DIV * (1 + T) + 1) begin errors++; $display("FAIL rearm_first_fall got=%0d exp=%0d", fall, DIV * (1 + T) + 1); end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (busy || sample_valid) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rearm_held_retrigger got=%0d busy cycles exp=0", extra); end
    @(negedge clk); start = 1'b0;
    capture(8'd9, 1'b0, 40);
    checks++; if (rise != 1) begin errors++; $display("FAIL rearm_second_rise got=%0d exp=1", rise); end
    checks++; if (nv != 1 + T) begin errors++; $display("FAIL rearm_second_pulses got=%0d exp=%0d", nv, 1 + T); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); sel = 8'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rst_L = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
    checks++; if (sample_out !== 8'h80) begin errors++; $display("FAIL midreset_out got=%h exp=80", sample_out); end
    @(posedge clk); #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midreset_dropped got=%0b exp=0", sample_valid); end
    @(negedge clk); rst_L = 1'b1;
    capture(8'd5, 1'b0, 40);
    checks++; if (nv != 3 + T) begin errors++; $display("FAIL midreset_replay_pulses got=%0d exp=%0d", nv, 3 + T); end
    checks++; if (vd[1] !== 8'h20) begin errors++; $display("FAIL midreset_replay_data got=%h exp=20", vd[1]); end
    checks++; if (fall != DIV * (3 + T) + 1) begin errors++; $display("FAIL midreset_replay_fall got=%0d exp=%0d", fall, DIV * (3 + T) + 1); end
  endtask

  // Reference: n = len + tail samples at offsets k*DIV; busy spans 1 cycle (invalid),
  // 2 cycles (no samples), or until one cycle after the last sample.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [7:0]  s;
      int          l, n, ef;
      logic [15:0] a;
      logic [7:0]  ed;
      s = 8'($urandom_range(0, 79));
      capture(s, 1'b0, 40);
      if (s >= NUM) begin
        n = 0; l = 0; ef = 2;
      end else begin
        l  = int'(len_mem[s]);
        n  = l + T;
        ef = (n == 0) ? 3 : DIV * n + 1;
      end
      checks++; if (rise != 1) begin errors++; $display("FAIL rand_rise sel=%0d got=%0d exp=1", s, rise); end
      checks++; if (fall != ef) begin errors++; $display("FAIL rand_fall sel=%0d got=%0d exp=%0d", s, fall, ef); end
      checks++; if (nv != n) begin errors++; $display("FAIL rand_pulses sel=%0d got=%0d exp=%0d", s, nv, n); end
      for (int k = 0; k < n; k++) begin
        a  = start_mem[s] + 16'(k);
        ed = (k < l) ? rom_mem[a] : 8'h80;
        checks++; if (vt[k] != DIV * (k + 1) || vd[k] !== ed) begin
          errors++; $display("FAIL rand_sample sel=%0d idx=%0d got=%h@%0d exp=%h@%0d", s, k, vd[k], vt[k], ed, DIV * (k + 1));
        end
      end
      checks++; if (end_out !== 8'h80) begin errors++; $display("FAIL rand_idle_out sel=%0d got=%h exp=80", s, end_out); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      start_mem[i] = 16'($urandom);
      len_mem[i]   = 16'($urandom_range(0, 5));
    end
    start_mem[5] = 16'h0100; len_mem[5] = 16'd3;
    rom_mem[16'h0100] = 8'h10; rom_mem[16'h0101] = 8'h20; rom_mem[16'h0102] = 8'h30;
    start_mem[7] = 16'hFFFF; len_mem[7] = 16'd2;
    start_mem[9] = 16'h2000; len_mem[9] = 16'd1;

    test_reset();
    test_basic();
    test_invalid();
    test_wrap();
    test_rearm();
    test_reset_mid();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
